// File: rtl/mat_result_collector.sv
// Collects up to MAX_N result rows from four processors (processor k owns rows k and k+4)
// and emits them strictly in row order through a registered valid/ready output stage.
module mat_result_collector #(
  parameter int DW    = 16,
  parameter int MAX_N = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          Enable,
  input  logic [3:0]    MAT_SIZE,
  input  logic [3:0]    P_VALID,
  input  logic [4*DW-1:0] P_DATA,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  output logic [2:0]    out_row,
  output logic          done,
  output logic          err
);

  localparam int AW = $clog2(MAX_N);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t         state, state_nxt;
  logic [3:0]     n;
  logic [3:0]     n_in;
  logic [MAX_N-1:0] filled;
  logic [1:0]     cnt [4];
  logic [3:0]     rd_ptr;
  logic [DW-1:0]  buffer [MAX_N];

  logic [3:0]     tgt [4];
  logic [3:0]     acc;
  logic [3:0]     drop;
  logic           load;
  logic           last_xfer;

  assign n_in = (MAT_SIZE > 4'(MAX_N)) ? 4'(MAX_N) : MAT_SIZE;

  // Classify each processor's offer: accept into its next owned row, or drop and flag.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    acc  = '0;
    drop = '0;
    for (int k = 0; k < 4; k++) begin
      tgt[k] = 4'(k) + {cnt[k], 2'b00};
      if (state == COLLECT && P_VALID[k]) begin
        if (cnt[k] < 2'd2 && tgt[k] < n && !filled[tgt[k][AW-1:0]])
          acc[k] = 1'b1;
        else
          drop[k] = 1'b1;
      end
    end
  end

  assign load      = (state == COLLECT) && (rd_ptr < n) && filled[rd_ptr[AW-1:0]] &&
                     (!out_valid || out_ready);
  assign last_xfer = (state == COLLECT) && out_valid && out_ready &&
                     ({1'b0, out_row} == n - 4'd1);

  always_comb begin
    state_nxt = state;
    if (!Enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = (n_in == 4'd0) ? DONE : COLLECT;
        COLLECT: if (last_xfer) state_nxt = DONE;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n         <= '0;
      filled    <= '0;
      rd_ptr    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_row   <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      for (int k = 0; k < 4; k++) cnt[k] <= '0;
    end else if (!Enable) begin
      filled    <= '0;
      rd_ptr    <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      for (int k = 0; k < 4; k++) cnt[k] <= '0;
    end else begin
      if (state == IDLE) n <= n_in;
      for (int k = 0; k < 4; k++) begin
        if (acc[k]) begin
          cnt[k]                     <= cnt[k] + 2'd1;
          filled[tgt[k][AW-1:0]]     <= 1'b1;
        end
      end
      if (|drop) err <= 1'b1;
      // A read only targets a filled slot and a write only an empty one, so they never collide.
      if (load) begin
        out_data                 <= buffer[rd_ptr[AW-1:0]];
        out_row                  <= rd_ptr[2:0];
        out_valid                <= 1'b1;
        rd_ptr                   <= rd_ptr + 4'd1;
        filled[rd_ptr[AW-1:0]]   <= 1'b0;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      done <= (state == DONE);
    end
  end

  // NOTE: the payload storage has no reset; the filled bits alone decide what is valid.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (acc[k]) buffer[tgt[k][AW-1:0]] <= P_DATA[k*DW +: DW];
    end
  end

endmodule

// File: tb/tb_mat_result_collector.sv
// Self-checking bench for mat_result_collector: table-driven scenarios with an in-order
// scoreboard, plus hand-written sequences for reset, abort and zero-size corner cases.
module tb_mat_result_collector;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          Enable;
  logic [3:0]    MAT_SIZE;
  logic [3:0]    P_VALID;
  logic [4*DW-1:0] P_DATA;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic [2:0]    out_row;
  logic          done;
  logic          err;

  mat_result_collector #(.DW(DW), .MAX_N(8)) dut (
    .clk(clk), .rst(rst), .Enable(Enable), .MAT_SIZE(MAT_SIZE), .P_VALID(P_VALID),
    .P_DATA(P_DATA), .out_ready(out_ready), .out_data(out_data), .out_valid(out_valid),
    .out_row(out_row), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   size;
    logic [15:0]  pv;    // beat b uses pv[4*b +: 4]
    logic [255:0] pd;    // beat b uses pd[64*b +: 64]
    int           stall;
    logic         exp_err;
    logic         b2b;
  } vec_t;

  typedef struct {
    logic [2:0]    row;
    logic [DW-1:0] data;
  } exp_t;

  vec_t vec [8];
  exp_t exp_q [$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   pop_cnt, first_pop, last_pop;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: every accepted output transfer must match the next expected row.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_row: got row %0d data %0h with nothing expected", out_row, out_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("row_idx", 64'(out_row), 64'(e.row));
        check("row_data", 64'(out_data), 64'(e.data));
        pop_cnt++;
        if (pop_cnt == 1) first_pop = cyc;
        last_pop = cyc;
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int      n, row, w;
    bit      filled [8];
    int      c [4];
    logic [DW-1:0] ex [8];
    logic [DW-1:0] exp0;
    n = (v.size > 4'd8) ? 8 : int'(v.size);
    for (int i = 0; i < 8; i++) begin filled[i] = 0; ex[i] = '0; end
    for (int k = 0; k < 4; k++) c[k] = 0;
    for (int b = 0; b < 4; b++)
      for (int k = 0; k < 4; k++)
        if (v.pv[4*b + k]) begin
          row = k + 4 * c[k];
          if (c[k] < 2 && row < n && !filled[row]) begin
            filled[row] = 1;
            ex[row] = v.pd[64*b + 16*k +: 16];
            c[k]++;
          end
        end
    out_ready = (v.stall == 0);
    Enable = 1'b0; P_VALID = '0;
    tick();
    pop_cnt = 0; first_pop = 0; last_pop = 0;
    for (int r = 0; r < n; r++) exp_q.push_back('{row: 3'(r), data: ex[r]});
    // Offers presented on the IDLE edge must be ignored.
    MAT_SIZE = v.size; Enable = 1'b1; P_VALID = 4'hF; P_DATA = 64'hDEAD_BEEF_DEAD_BEEF;
    tick();
    MAT_SIZE = 4'd1;
    for (int b = 0; b < 4; b++) begin
      P_VALID = v.pv[4*b +: 4];
      P_DATA  = v.pd[64*b +: 64];
      tick();
    end
    P_VALID = '0;
    if (v.stall > 0) begin
      w = 0;
      while (!out_valid && w < 20) begin tick(); w++; end
      check("stall_valid", 64'(out_valid), 64'd1);
      exp0 = ex[0];
      for (int i = 0; i < v.stall; i++) begin
        check("stall_data", 64'(out_data), 64'(exp0));
        check("stall_row", 64'(out_row), 64'd0);
        tick();
      end
      out_ready = 1'b1;
    end
    w = 0;
    while (!done && w < 60) begin tick(); w++; end
    check("done", 64'(done), 64'd1);
    check("err", 64'(err), 64'(v.exp_err));
    check("rows_left", 64'(exp_q.size()), 64'd0);
    check("valid_in_done", 64'(out_valid), 64'd0);
    if (v.b2b) check("back_to_back_span", 64'(last_pop - first_pop), 64'(n - 1));
  endtask

  initial begin
    int w;
    vec[0] = '{4'd4, 16'h8421, {128'h0, {4{16'd40}}, {4{16'd30}}, {4{16'd20}}, {4{16'd10}}}, 0, 1'b0, 1'b0};
    vec[1] = '{4'd8, 16'h00FF, {128'h0, 64'h00B3_00B2_00B1_00B0, 64'h00A3_00A2_00A1_00A0}, 0, 1'b0, 1'b1};
    vec[2] = '{4'd3, 16'h4218, {{4{16'h0033}}, {4{16'h0022}}, {4{16'h0011}}, {4{16'h00EE}}}, 0, 1'b1, 1'b0};
    vec[3] = '{4'd12, 16'h00FF, {128'h0, 64'h2004_2003_2002_2001, 64'h1004_1003_1002_1001}, 0, 1'b0, 1'b1};
    vec[4] = '{4'd2, 16'h0033, {128'h0, 64'h0053_0052_0053_0052, 64'h0000_0000_0051_0050}, 0, 1'b1, 1'b0};
    vec[5] = '{4'd5, 16'hC112, {64'h0063_0062_0000_0000, {4{16'h0064}}, {4{16'h0060}}, {4{16'h0061}}}, 0, 1'b0, 1'b0};
    vec[6] = '{4'd4, 16'h000F, {192'h0, 64'h0073_0072_0071_0070}, 5, 1'b0, 1'b0};
    vec[7] = '{4'd2, 16'h0003, {192'h0, 64'h0000_0000_0081_0080}, 0, 1'b0, 1'b0};

    rst = 1'b0; Enable = 1'b0; MAT_SIZE = '0; P_VALID = '0; P_DATA = '0; out_ready = 1'b1;
    #12;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_row", 64'(out_row), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) run_vec(vec[i]);

    // Abort after row 1 has gone out, then re-run a small matrix from row 0.
    Enable = 1'b0; out_ready = 1'b1; tick();
    pop_cnt = 0;
    for (int r = 0; r < 4; r++) exp_q.push_back('{row: 3'(r), data: 16'(16'h90 + r)});
    MAT_SIZE = 4'd4; Enable = 1'b1; tick();
    P_VALID = 4'hF; P_DATA = 64'h0093_0092_0091_0090; tick();
    P_VALID = '0;
    w = 0;
    while (pop_cnt < 2 && w < 20) begin tick(); w++; end
    check("abort_rows_seen", 64'(pop_cnt >= 2), 64'd1);
    Enable = 1'b0; tick();
    exp_q.delete();
    check("abort_valid", 64'(out_valid), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    run_vec(vec[7]);

    // Reset in the middle of collection discards everything buffered.
    Enable = 1'b0; out_ready = 1'b0; tick();
    MAT_SIZE = 4'd4; Enable = 1'b1; tick();
    P_VALID = 4'hF; P_DATA = 64'h00A7_00A6_00A5_00A4; tick();
    P_VALID = 4'h8; tick();
    P_VALID = '0;
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    #2 rst = 1'b0; Enable = 1'b0;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_data", 64'(out_data), 64'd0);
    check("async_rst_err", 64'(err), 64'd0);
    tick();
    rst = 1'b1; Enable = 1'b1; MAT_SIZE = 4'd4;
    for (int i = 0; i < 5; i++) tick();
    check("post_rst_valid", 64'(out_valid), 64'd0);
    check("post_rst_done", 64'(done), 64'd0);

    // Zero-size matrix: done after two edges, no output, offers in DONE/IDLE ignored.
    Enable = 1'b0; out_ready = 1'b1; P_VALID = 4'hF; tick();
    check("idle_offer_err", 64'(err), 64'd0);
    P_VALID = '0; MAT_SIZE = 4'd0; Enable = 1'b1;
    tick();
    check("n0_done_edge1", 64'(done), 64'd0);
    tick();
    check("n0_done_edge2", 64'(done), 64'd1);
    check("n0_valid", 64'(out_valid), 64'd0);
    P_VALID = 4'hF; tick(); tick();
    P_VALID = '0;
    check("done_offer_err", 64'(err), 64'd0);
    check("done_hold", 64'(done), 64'd1);
    Enable = 1'b0; tick();
    check("done_clear", 64'(done), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
